// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl
//
// Next-PC selection and pipeline-flush control for a five-stage core with a
// single-level external interrupt.  EX-stage redirects (branch / JAL / JALR),
// interrupt entry and MRET return are resolved here into a next-PC select,
// a PC write enable and IF/ID + ID/EX bubble requests.
//
// Ports
//   clk         sole clock, rising edge
//   rstn        asynchronous active-low reset
//   int_req     level-sensitive external interrupt request
//   stall       load-use hold from the hazard unit
//   branch_ex   taken branch resolved in EX
//   jump_ex     JAL resolved in EX
//   jalr_ex     JALR resolved in EX
//   mret_ex     MRET resolved in EX
//   pc_if       PC of the instruction currently in fetch
//   npc_op      next-PC select: PLUS4=000 BRANCH=001 JUMP=010 INT=011 JALR=100
//   pcwrite     PC update enable
//   mret        MRET select (PC <- sepc)
//   flush_ifid  bubble into IF/ID
//   flush_idex  bubble into ID/EX
//   sepc        saved resume PC, 0 when nothing is saved
//   in_handler  high while in ENTRY or HANDLER
//   int_count   (PC_REDIRECT_TRAP_COUNT_EN only) wrapping count of trap entries
//
// Optional feature: define PC_REDIRECT_TRAP_COUNT_EN to add the 16-bit
// int_count output and its counter.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | normal execution, interrupt may be accepted
// ENTRY   | one cycle: steer fetch to the trap vector, flush the pipe
// HANDLER | running the handler, further interrupts ignored
// RETURN  | one cycle after MRET: sepc is cleared on the way to IDLE

module pc_redirect_ctrl (
    input  logic        clk,
    input  logic        rstn,
    input  logic        int_req,
    input  logic        stall,
    input  logic        branch_ex,
    input  logic        jump_ex,
    input  logic        jalr_ex,
    input  logic        mret_ex,
    input  logic [31:0] pc_if,
    output logic [2:0]  npc_op,
    output logic        pcwrite,
    output logic        mret,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic [31:0] sepc,
    output logic        in_handler
`ifdef PC_REDIRECT_TRAP_COUNT_EN
    ,
    output logic [15:0] int_count
`endif
);

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_INT    = 3'b011;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTRY   = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] sepc_q, sepc_d;
    logic        in_handler_q, in_handler_d;

    logic ex_redirect;
    logic take_int;
    logic take_mret;

    assign ex_redirect = branch_ex | jump_ex | jalr_ex;
    // An interrupt is only taken on a clean IDLE cycle; otherwise it simply
    // stays pending on the level of int_req and is looked at again next cycle.
    assign take_int    = (state_q == ST_IDLE) & int_req & ~stall & ~ex_redirect;
    assign take_mret   = (state_q == ST_HANDLER) & mret_ex;

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            sepc_q       <= 32'h0000_0000;
            in_handler_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sepc_q       <= sepc_d;
            in_handler_q <= in_handler_d;
        end
    end

    // next-state
    always_comb begin
        state_d = state_q;
        sepc_d  = sepc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (take_int) begin
                    state_d = ST_ENTRY;
                    sepc_d  = pc_if;
                end
            end
            ST_ENTRY: begin
                state_d = ST_HANDLER;
            end
            ST_HANDLER: begin
                if (take_mret) begin
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN: begin
                state_d = ST_IDLE;
                sepc_d  = 32'h0000_0000;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_handler_d = (state_d == ST_ENTRY) || (state_d == ST_HANDLER);
    end

    // outputs
    always_comb begin
        npc_op     = NPC_PLUS4;
        pcwrite    = ~stall;
        mret       = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        if (!rstn) begin
            // Reset holds the fetch path in a benign free-running state,
            // independent of whatever the hazard unit is asserting.
            pcwrite = 1'b1;
        end else if (state_q == ST_ENTRY) begin
            npc_op     = NPC_INT;
            pcwrite    = 1'b1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (take_mret) begin
            mret       = 1'b1;
            pcwrite    = 1'b1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (ex_redirect) begin
            if (jalr_ex) begin
                npc_op = NPC_JALR;
            end else if (jump_ex) begin
                npc_op = NPC_JUMP;
            end else begin
                npc_op = NPC_BRANCH;
            end
            pcwrite    = 1'b1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end
    end

    assign sepc       = sepc_q;
    assign in_handler = in_handler_q;

`ifdef PC_REDIRECT_TRAP_COUNT_EN
    logic [15:0] int_count_q, int_count_d;

    always_comb begin
        int_count_d = int_count_q;
        if (take_int) begin
            int_count_d = int_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            int_count_q <= 16'h0000;
        end else begin
            int_count_q <= int_count_d;
        end
    end

    assign int_count = int_count_q;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
module tb_pc_redirect_ctrl;

    logic        clk;
    logic        rstn;
    logic        int_req, stall, branch_ex, jump_ex, jalr_ex, mret_ex;
    logic [31:0] pc_if;
    logic [2:0]  npc_op;
    logic        pcwrite, mret, flush_ifid, flush_idex, in_handler;
    logic [31:0] sepc;
`ifdef PC_REDIRECT_TRAP_COUNT_EN
    logic [15:0] int_count;
`endif

    int checks = 0;
    int errors = 0;

    pc_redirect_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .int_req    (int_req),
        .stall      (stall),
        .branch_ex  (branch_ex),
        .jump_ex    (jump_ex),
        .jalr_ex    (jalr_ex),
        .mret_ex    (mret_ex),
        .pc_if      (pc_if),
        .npc_op     (npc_op),
        .pcwrite    (pcwrite),
        .mret       (mret),
        .flush_ifid (flush_ifid),
        .flush_idex (flush_idex),
        .sepc       (sepc),
        .in_handler (in_handler)
`ifdef PC_REDIRECT_TRAP_COUNT_EN
        ,
        .int_count  (int_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        i_int, i_stall, i_br, i_jmp, i_jalr, i_mret;
        logic [31:0] i_pc;
        logic [2:0]  e_npc;
        logic        e_pw, e_mret, e_fl, e_ih;
        logic [31:0] e_sepc;
    } vec_t;

    function automatic vec_t mk(logic ir, logic st, logic br, logic jp, logic jr,
                                logic mr, logic [31:0] pc, logic [2:0] enpc,
                                logic epw, logic emr, logic efl, logic eih,
                                logic [31:0] esepc);
        vec_t v;
        v.i_int = ir;  v.i_stall = st; v.i_br = br; v.i_jmp = jp;
        v.i_jalr = jr; v.i_mret = mr;  v.i_pc = pc;
        v.e_npc = enpc; v.e_pw = epw; v.e_mret = emr; v.e_fl = efl;
        v.e_ih = eih;   v.e_sepc = esepc;
        return v;
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s #%0d actual=%0h required=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(string tag, int idx, logic [2:0] enpc, logic epw,
                           logic emr, logic efl, logic eih, logic [31:0] esepc);
        chk({tag, ".npc_op"}, idx, {29'd0, npc_op}, {29'd0, enpc});
        chk({tag, ".pcwrite"}, idx, {31'd0, pcwrite}, {31'd0, epw});
        chk({tag, ".mret"}, idx, {31'd0, mret}, {31'd0, emr});
        chk({tag, ".flush_ifid"}, idx, {31'd0, flush_ifid}, {31'd0, efl});
        chk({tag, ".flush_idex"}, idx, {31'd0, flush_idex}, {31'd0, efl});
        chk({tag, ".in_handler"}, idx, {31'd0, in_handler}, {31'd0, eih});
        chk({tag, ".sepc"}, idx, sepc, esepc);
    endtask

    task automatic drive(logic ir, logic st, logic br, logic jp, logic jr,
                         logic mr, logic [31:0] pc);
        int_req = ir; stall = st; branch_ex = br; jump_ex = jp;
        jalr_ex = jr; mret_ex = mr; pc_if = pc;
    endtask

    // Called at posedge+1: assert reset, hold across two edges, release.
    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        rstn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Reference model: trap life cycle as plain flags
    bit          m_entry, m_trap, m_ret;
    logic [31:0] m_sepc;
    logic [15:0] m_cnt;

    vec_t vecs[17];

    initial begin
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        rstn = 1'b0;
        #2;
        chk_all("reset", 0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        stall = 1'b1; jalr_ex = 1'b1; int_req = 1'b1;
        #1;
        chk_all("reset_busy_in", 0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        do_reset();

        //         int st br jp jr mr pc            npc    pw mr fl ih sepc
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 32'h10,  3'b000, 1, 0, 0, 0, 32'h0);
        vecs[1]  = mk(0, 1, 0, 0, 0, 0, 32'h14,  3'b000, 0, 0, 0, 0, 32'h0);
        vecs[2]  = mk(0, 1, 0, 0, 1, 0, 32'h14,  3'b100, 1, 0, 1, 0, 32'h0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 1, 32'h18,  3'b000, 1, 0, 0, 0, 32'h0);
        vecs[4]  = mk(1, 0, 0, 0, 0, 0, 32'h40,  3'b000, 1, 0, 0, 0, 32'h0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 32'h44,  3'b011, 1, 0, 1, 1, 32'h40);
        vecs[6]  = mk(1, 0, 0, 0, 0, 0, 32'h200, 3'b000, 1, 0, 0, 1, 32'h40);
        vecs[7]  = mk(1, 1, 0, 0, 0, 0, 32'h204, 3'b000, 0, 0, 0, 1, 32'h40);
        vecs[8]  = mk(1, 0, 0, 0, 0, 1, 32'h204, 3'b000, 1, 1, 1, 1, 32'h40);
        vecs[9]  = mk(1, 0, 0, 0, 0, 0, 32'h300, 3'b000, 1, 0, 0, 0, 32'h40);
        vecs[10] = mk(1, 0, 1, 0, 0, 0, 32'h80,  3'b001, 1, 0, 1, 0, 32'h0);
        vecs[11] = mk(1, 0, 0, 0, 0, 0, 32'h84,  3'b000, 1, 0, 0, 0, 32'h0);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 32'h88,  3'b011, 1, 0, 1, 1, 32'h84);
        vecs[13] = mk(0, 0, 1, 1, 0, 0, 32'h200, 3'b010, 1, 0, 1, 1, 32'h84);
        vecs[14] = mk(0, 1, 0, 0, 1, 1, 32'h204, 3'b000, 1, 1, 1, 1, 32'h84);
        vecs[15] = mk(1, 1, 0, 0, 0, 0, 32'h300, 3'b000, 0, 0, 0, 0, 32'h84);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 32'h304, 3'b000, 1, 0, 0, 0, 32'h0);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].i_int, vecs[i].i_stall, vecs[i].i_br, vecs[i].i_jmp,
                  vecs[i].i_jalr, vecs[i].i_mret, vecs[i].i_pc);
            #1;
            chk_all("vec", i, vecs[i].e_npc, vecs[i].e_pw, vecs[i].e_mret,
                    vecs[i].e_fl, vecs[i].e_ih, vecs[i].e_sepc);
            @(posedge clk);
            #1;
        end
`ifdef PC_REDIRECT_TRAP_COUNT_EN
        chk("int_count_table", 0, {16'd0, int_count}, 32'd2);
`endif

        // Randomized run against the flag model
        do_reset();
        m_entry = 0; m_trap = 0; m_ret = 0; m_sepc = 32'h0; m_cnt = 16'h0;
        for (int c = 0; c < 3000; c++) begin
            logic [2:0]  e_npc;
            logic        e_pw, e_mr, e_fl, any_red, accept;
            drive($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 8,
                  $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 20,
                  $urandom & 32'hFFFF_FFFC);
            any_red = branch_ex | jump_ex | jalr_ex;
            e_mr = 1'b0;
            if (m_entry) begin
                e_npc = 3'd3; e_pw = 1'b1; e_fl = 1'b1;
            end else if (m_trap && mret_ex) begin
                e_npc = 3'd0; e_pw = 1'b1; e_fl = 1'b1; e_mr = 1'b1;
            end else if (any_red) begin
                e_npc = jalr_ex ? 3'd4 : (jump_ex ? 3'd2 : 3'd1);
                e_pw = 1'b1; e_fl = 1'b1;
            end else begin
                e_npc = 3'd0; e_pw = !stall; e_fl = 1'b0;
            end
            #1;
            chk_all("rand", c, e_npc, e_pw, e_mr, e_fl, m_entry || m_trap, m_sepc);
`ifdef PC_REDIRECT_TRAP_COUNT_EN
            chk("rand.int_count", c, {16'd0, int_count}, {16'd0, m_cnt});
`endif
            accept = !m_entry && !m_trap && !m_ret && int_req && !stall && !any_red;
            if (m_entry) begin
                m_entry = 0; m_trap = 1;
            end else if (m_trap && mret_ex) begin
                m_trap = 0; m_ret = 1;
            end else if (m_ret) begin
                m_ret = 0; m_sepc = 32'h0;
            end else if (accept) begin
                m_entry = 1; m_sepc = pc_if; m_cnt = m_cnt + 16'd1;
            end
            @(posedge clk);
            #1;
        end

        // Reset in the middle of a handler
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 32'h100);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 32'h104);
        @(posedge clk);
        #1;
        drive(1, 1, 0, 0, 1, 0, 32'h200);
        #1;
        chk_all("pre_rst", 0, 3'b100, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100);
        rstn = 1'b0;
        #1;
        chk_all("async_rst", 0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        mret_ex = 1'b1;
        #1;
        chk_all("async_rst_mret", 0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
`ifdef PC_REDIRECT_TRAP_COUNT_EN
        chk("async_rst.int_count", 0, {16'd0, int_count}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rstn = 1'b1;
        drive(0, 0, 0, 0, 0, 1, 32'h300);
        #1;
        chk_all("post_rst_mret", 0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        chk_all("post_rst_idle", 0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
